// File: rtl/wrr_arbiter_param.sv
// Weighted round-robin arbiter: one registered grant at a time, held until ack,
// with per-requestor programmable burst weights (weight 0 masks the requestor).
module wrr_arbiter_param #(
  parameter  int N_REQ  = 32,
  parameter  int WT_W   = 4,
  parameter  int WT_RST = 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic                  ack,
  input  logic [N_REQ*WT_W-1:0] wt_cfg,
  input  logic                  wt_ld,
  output logic [N_REQ-1:0]      gnt_w,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  gnt_vld
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                      state_reg;
  logic [ID_W-1:0]             ptr_reg;
  logic [WT_W-1:0]             credit_reg;
  logic [N_REQ-1:0][WT_W-1:0]  weight_reg;
  logic [N_REQ-1:0]            gnt_w_reg;
  logic [ID_W-1:0]             gnt_id_reg;
  logic                        gnt_vld_reg;

  logic [N_REQ-1:0][WT_W-1:0]  weight_eff;
  logic [N_REQ-1:0]            elig;
  logic [ID_W-1:0]             nxt_ptr;
  logic [ID_W-1:0]             search_start;
  logic                        found;
  logic [ID_W-1:0]             win;
  logic                        burst_cont;

  // A search in the same cycle as wt_ld already sees the new weights.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign weight_eff[gi] = wt_ld ? wt_cfg[gi*WT_W +: WT_W] : weight_reg[gi];
    assign elig[gi]       = req[gi] && (weight_eff[gi] != '0);
  end

  assign nxt_ptr      = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + 1'b1;
  assign search_start = (state_reg == GRANT) ? nxt_ptr : ptr_reg;

  // Burst decision deliberately uses the weight that was in force before any wt_ld.
  assign burst_cont = (credit_reg > WT_W'(1)) && req[gnt_id_reg] &&
                      (weight_reg[gnt_id_reg] != '0);

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(search_start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_reg <= {N_REQ{WT_W'(WT_RST)}};
    end else if (wt_ld) begin
      weight_reg <= wt_cfg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      credit_reg  <= '0;
      gnt_w_reg   <= '0;
      gnt_id_reg  <= '0;
      gnt_vld_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg   <= GRANT;
            gnt_id_reg  <= win;
            gnt_w_reg   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gnt_vld_reg <= 1'b1;
            credit_reg  <= weight_eff[win];
          end
        end
        GRANT: begin
          if (ack) begin
            if (burst_cont) begin
              credit_reg <= credit_reg - 1'b1;
            end else begin
              ptr_reg <= nxt_ptr;
              if (found) begin
                gnt_id_reg <= win;
                gnt_w_reg  <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                credit_reg <= weight_eff[win];
              end else begin
                state_reg   <= IDLE;
                gnt_w_reg   <= '0;
                gnt_vld_reg <= 1'b0;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt_w   = gnt_w_reg;
  assign gnt_id  = gnt_id_reg;
  assign gnt_vld = gnt_vld_reg;

endmodule
